// File: rtl/mu_broadcast_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mu_broadcast_scheduler_pkg
// Types and constants shared by the motion-update broadcast scheduler, its
// round-robin arbiter and anything that builds broadcast destinations.
//   sched_state_t : pass sequencing states
//   POS_WIDTH     : default width of one position component
//   CELL_WIDTH    : default width of one cell coordinate
//   pack_cell()   : packs {x,y,z} cell coordinates, x in the MSBs
// ---------------------------------------------------------------------------
package mu_broadcast_scheduler_pkg;

    localparam int POS_WIDTH  = 32;
    localparam int CELL_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BROADCAST,
        ST_DRAIN,
        ST_SETTLE,
        ST_DONE
    } sched_state_t;

    function automatic logic [3*CELL_WIDTH-1:0] pack_cell(
        input logic [CELL_WIDTH-1:0] x,
        input logic [CELL_WIDTH-1:0] y,
        input logic [CELL_WIDTH-1:0] z
    );
        return {x, y, z};
    endfunction

endpackage

// File: rtl/mu_broadcast_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search for a requester starts at the index after
// the last accepted grant; the pointer returns to 0 on reset.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   accept    : the current grant was taken this cycle (advances pointer)
//   grant     : one-hot grant, or zero when nothing requests
//   grant_idx : binary index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the requesters starting at the pointer; the first one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_reg) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (accept && found) begin
            ptr_reg <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mu_broadcast_scheduler.sv
// ---------------------------------------------------------------------------
// mu_broadcast_scheduler
// Sequences one motion-update pass: frames it with motion_update_enable,
// collects particles from NUM_SRC motion-update units round-robin onto the
// single broadcast bus, then holds enable low for SETTLE_CYCLES so the cell
// caches can write their counts and swap buffers before done pulses.
//
// Optional feature: define MU_SCHED_CELL_CHECK_EN to drop (accept but not
// broadcast) particles whose destination has a coordinate of 0 or above
// CELL_MAX, raising the sticky cell_error flag. Without it cell_error is 0.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : pass start pulse, honoured only when idle
//   src_valid/src_ready  : per-source handshake (src_ready combinational)
//   src_data             : per-source {posz,posy,posx}, source 0 in LSBs
//   src_dst_cell         : per-source {x,y,z} destination cell
//   src_done             : per-source "no more particles this pass"
//   motion_update_enable : broadcast frame to all caches
//   out_data/out_dst_cell/out_data_valid : registered broadcast beat
//   busy, done           : pass in progress / one-cycle end-of-pass pulse
//   broadcast_count      : saturating count of particles broadcast
//   cell_error           : sticky illegal-destination flag
// ---------------------------------------------------------------------------
module mu_broadcast_scheduler
    import mu_broadcast_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH    = POS_WIDTH,
    parameter int CELL_ID_WIDTH = CELL_WIDTH,
    parameter int NUM_SRC       = 4,
    parameter int CELL_MAX      = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [NUM_SRC-1:0]                 src_valid,
    output logic [NUM_SRC-1:0]                 src_ready,
    input  logic [NUM_SRC*3*DATA_WIDTH-1:0]    src_data,
    input  logic [NUM_SRC*3*CELL_ID_WIDTH-1:0] src_dst_cell,
    input  logic [NUM_SRC-1:0]                 src_done,
    output logic                               motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]            out_data,
    output logic [3*CELL_ID_WIDTH-1:0]         out_dst_cell,
    output logic                               out_data_valid,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_WIDTH-1:0]               broadcast_count,
    output logic                               cell_error
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int PD = 3 * DATA_WIDTH;
    localparam int PC = 3 * CELL_ID_WIDTH;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

`ifdef MU_SCHED_CELL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    sched_state_t          state_reg;
    logic [SW-1:0]         settle_cnt_reg;
    logic                  enable_reg;
    logic [PD-1:0]         out_data_reg;
    logic [PC-1:0]         out_dst_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  cell_error_reg;

    // Unpack the flat source buses into per-source lanes.
    logic [PD-1:0] data_arr [NUM_SRC];
    logic [PC-1:0] dst_arr  [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            assign data_arr[gi] = src_data[gi*PD +: PD];
            assign dst_arr[gi]  = src_dst_cell[gi*PC +: PC];
        end
    endgenerate

    logic                     all_done;
    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0]       grant;
    logic [PW-1:0]            grant_idx;
    logic                     handshake;
    logic [PD-1:0]            sel_data;
    logic [PC-1:0]            sel_dst;
    logic [CELL_ID_WIDTH-1:0] cx, cy, cz;
    logic                     coord_ok;
    logic                     dst_ok;

    assign all_done = &src_done;

    // Requests are only offered while broadcasting and some source is still
    // live; a source that has declared done is never granted.
    assign req = (state_reg == ST_BROADCAST && !all_done) ? (src_valid & ~src_done) : '0;

    rr_arbiter #(
        .N(NUM_SRC)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .accept    (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign handshake = |grant;
    assign src_ready = grant;
    assign sel_data  = data_arr[grant_idx];
    assign sel_dst   = dst_arr[grant_idx];

    assign cx = sel_dst[3*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH];
    assign cy = sel_dst[2*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH];
    assign cz = sel_dst[CELL_ID_WIDTH-1:0];

    // Coordinates are 1-based; 0 and anything past CELL_MAX name no cell.
    assign coord_ok = (cx != '0) && (cx <= CELL_ID_WIDTH'(CELL_MAX)) &&
                      (cy != '0) && (cy <= CELL_ID_WIDTH'(CELL_MAX)) &&
                      (cz != '0) && (cz <= CELL_ID_WIDTH'(CELL_MAX));
    assign dst_ok   = !CHECK_EN || coord_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            enable_reg     <= 1'b0;
            out_data_reg   <= '0;
            out_dst_reg    <= '0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            count_reg      <= '0;
            cell_error_reg <= 1'b0;
        end else begin
            // The broadcast beat only lives for the cycle after a handshake.
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_dst_reg   <= '0;
            done_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_START;
                        enable_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        count_reg      <= '0;
                        cell_error_reg <= 1'b0;
                    end
                end

                ST_START: begin
                    // With every source already finished there is nothing to
                    // arbitrate, so the frame closes after just two cycles.
                    state_reg <= all_done ? ST_DRAIN : ST_BROADCAST;
                end

                ST_BROADCAST: begin
                    if (all_done) begin
                        state_reg <= ST_DRAIN;
                    end else if (handshake) begin
                        if (dst_ok) begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= sel_data;
                            out_dst_reg   <= sel_dst;
                            if (count_reg != {CNT_WIDTH{1'b1}}) begin
                                count_reg <= count_reg + 1'b1;
                            end
                        end else begin
                            cell_error_reg <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    state_reg      <= ST_SETTLE;
                    enable_reg     <= 1'b0;
                    settle_cnt_reg <= SW'(SETTLE_CYCLES - 1);
                end

                ST_SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 1'b1;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    enable_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign motion_update_enable = enable_reg;
    assign out_data             = out_data_reg;
    assign out_dst_cell         = out_dst_reg;
    assign out_data_valid       = out_valid_reg;
    assign busy                 = busy_reg;
    assign done                 = done_reg;
    assign broadcast_count      = count_reg;
    assign cell_error           = CHECK_EN & cell_error_reg;

endmodule

// File: tb/tb_mu_broadcast_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mu_broadcast_scheduler
// Randomised bench for mu_broadcast_scheduler. Each source holds a queue of
// particles; a pass is judged against the frame rules (enable from START to
// DRAIN, SETTLE_CYCLES quiet cycles, one done pulse) and a round-robin
// reference. Accepted particles are pushed onto a scoreboard that a separate
// monitor drains as beats appear on the broadcast bus.
// ---------------------------------------------------------------------------
module tb_mu_broadcast_scheduler;
    import mu_broadcast_scheduler_pkg::*;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = 4;
    localparam int SC   = 4;
    localparam int CNTW = 16;
    localparam int PD   = 3 * DW;
    localparam int PC   = 3 * CW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [NS*PD-1:0]     src_data;
    logic [NS*PC-1:0]     src_dst_cell;
    logic [NS-1:0]        src_done;
    logic                 motion_update_enable;
    logic [PD-1:0]        out_data;
    logic [PC-1:0]        out_dst_cell;
    logic                 out_data_valid;
    logic                 busy;
    logic                 done;
    logic [CNTW-1:0]      broadcast_count;
    logic                 cell_error;

    mu_broadcast_scheduler #(
        .DATA_WIDTH    (DW),
        .CELL_ID_WIDTH (CW),
        .NUM_SRC       (NS),
        .CELL_MAX      (CMAX),
        .SETTLE_CYCLES (SC),
        .CNT_WIDTH     (CNTW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .src_valid            (src_valid),
        .src_ready            (src_ready),
        .src_data             (src_data),
        .src_dst_cell         (src_dst_cell),
        .src_done             (src_done),
        .motion_update_enable (motion_update_enable),
        .out_data             (out_data),
        .out_dst_cell         (out_dst_cell),
        .out_data_valid       (out_data_valid),
        .busy                 (busy),
        .done                 (done),
        .broadcast_count      (broadcast_count),
        .cell_error           (cell_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PD-1:0] data;
        logic [PC-1:0] dst;
    } part_t;

    typedef struct {
        logic [PD-1:0] data;
        logic [PC-1:0] dst;
        int            cyc;
    } beat_t;

    part_t srcq [NS][$];
    beat_t sb[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int rr_ptr    = 0;
    int cnt_model = 0;
    bit cerr_model = 1'b0;
    bit mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // A destination names a real cell only when every coordinate is 1..CMAX.
    function automatic bit legal(input logic [PC-1:0] d);
`ifdef MU_SCHED_CELL_CHECK_EN
        int x, y, z;
        x = int'(d[3*CW-1 -: CW]);
        y = int'(d[2*CW-1 -: CW]);
        z = int'(d[CW-1:0]);
        return (x >= 1 && x <= CMAX) && (y >= 1 && y <= CMAX) && (z >= 1 && z <= CMAX);
`else
        return (d === d);
`endif
    endfunction

    function automatic part_t mk(input int x, input int y, input int z);
        part_t p;
        p.data = {$urandom, $urandom, $urandom};
        p.dst  = pack_cell(CW'(x), CW'(y), CW'(z));
        return p;
    endfunction

    function automatic part_t mk_rand();
        if ($urandom_range(0, 7) == 0)
            return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        return mk($urandom_range(1, CMAX), $urandom_range(1, CMAX), $urandom_range(1, CMAX));
    endfunction

    // Monitor: every broadcast beat must match the oldest accepted particle
    // and arrive exactly one cycle after its handshake.
    always @(negedge clk) begin
        beat_t b;
        if (mon_en) begin
            if (out_data_valid === 1'b1) begin
                chk("enable_with_valid", 128'(motion_update_enable), 128'(1));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected @cycle %0d: got beat %0h, expected none", cyc, out_data);
                end else begin
                    b = sb.pop_front();
                    chk("beat_cycle", 128'(cyc), 128'(b.cyc));
                    chk("beat_data", 128'(out_data), 128'(b.data));
                    chk("beat_dst", 128'(out_dst_cell), 128'(b.dst));
                end
            end else begin
                chk("idle_bus", 128'({out_data_valid, out_data, out_dst_cell}), 128'(0));
            end
        end
    end

    task automatic clear_queues();
        for (int i = 0; i < NS; i++) srcq[i].delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enable"}, 128'(motion_update_enable), 128'(0));
        chk({tag, "_valid"}, 128'(out_data_valid), 128'(0));
        chk({tag, "_bus"}, 128'({out_data, out_dst_cell}), 128'(0));
        chk({tag, "_busy_done"}, 128'({busy, done}), 128'(0));
        chk({tag, "_count"}, 128'(broadcast_count), 128'(0));
        chk({tag, "_cell_error"}, 128'(cell_error), 128'(0));
        chk({tag, "_src_ready"}, 128'(src_ready), 128'(0));
    endtask

    task automatic model_reset();
        rr_ptr     = 0;
        cnt_model  = 0;
        cerr_model = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; src_valid = '0;
        @(negedge clk);
        model_reset();
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    // One pass. Cycle 0 carries start. E is the first cycle >=1 where every
    // source reports done: enable spans 1..E+1, SETTLE is E+2..E+1+SC, done
    // pulses at E+2+SC and the scheduler is idle again at E+3+SC.
    // late >= 0 re-pulses start inside SETTLE; abort_c >= 0 resets mid-pass.
    task automatic run_pass(input int prob, input int late, input int abort_c);
        int            e_cyc;
        int            g;
        int            idx;
        bit            fin;
        logic [NS-1:0] v, d, exp_g;
        part_t         p;
        e_cyc = -1;
        fin   = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            chk("enable", 128'(motion_update_enable), 128'(c >= 1 && (e_cyc < 0 || c <= e_cyc + 1)));
            chk("busy", 128'(busy), 128'(c >= 1 && (e_cyc < 0 || c <= e_cyc + 2 + SC)));
            chk("done", 128'(done), 128'(e_cyc >= 0 && c == e_cyc + 2 + SC));
            chk("broadcast_count", 128'(broadcast_count), 128'(cnt_model));
            chk("cell_error", 128'(cell_error), 128'(cerr_model));
            if (c == abort_c) begin
                rst = 1'b1; start = 1'b0; src_valid = '0;
                @(negedge clk);
                model_reset();
                check_all_zero("mid_pass_reset");
                rst = 1'b0;
                clear_queues();
                fin = 1'b1;
            end else if (e_cyc >= 0 && c == e_cyc + 3 + SC) begin
                start = 1'b0; src_valid = '0;
                fin = 1'b1;
            end else begin
                start = (c == 0) || (late >= 0 && e_cyc >= 0 && c == e_cyc + 2 + late);
                for (int i = 0; i < NS; i++) begin
                    d[i] = (srcq[i].size() == 0);
                    v[i] = d[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) < prob);
                    if (d[i]) begin
                        src_data[i*PD +: PD]     = {$urandom, $urandom, $urandom};
                        src_dst_cell[i*PC +: PC] = PC'($urandom);
                    end else begin
                        src_data[i*PD +: PD]     = srcq[i][0].data;
                        src_dst_cell[i*PC +: PC] = srcq[i][0].dst;
                    end
                end
                src_valid = v;
                src_done  = d;
                if (c >= 1 && e_cyc < 0 && (&d)) e_cyc = c;
                #1;
                g = -1;
                if (c >= 2 && e_cyc < 0) begin
                    for (int k = 0; k < NS; k++) begin
                        idx = (rr_ptr + k) % NS;
                        if (g < 0 && v[idx] && !d[idx]) g = idx;
                    end
                end
                exp_g = '0;
                if (g >= 0) exp_g[g] = 1'b1;
                chk("src_ready", 128'(src_ready), 128'(exp_g));
                if (c == 0) begin
                    cnt_model  = 0;
                    cerr_model = 1'b0;
                end
                if (g >= 0) begin
                    p = srcq[g].pop_front();
                    rr_ptr = (g + 1) % NS;
                    if (legal(p.dst)) begin
                        sb.push_back('{data: p.data, dst: p.dst, cyc: cyc + 1});
                        cnt_model++;
                    end else begin
                        cerr_model = 1'b1;
                    end
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout @cycle %0d: got no return to idle, expected one within 400 cycles", cyc);
            start = 1'b0; src_valid = '0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_valid = '0; src_done = '0;
        src_data = '0; src_dst_cell = '0;
        repeat (3) @(negedge clk);
        model_reset();
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Single source, three particles to cell {1,1,1}.
        for (int n = 0; n < 3; n++) srcq[0].push_back(mk(1, 1, 1));
        run_pass(100, -1, -1);

        // Every source streaming two particles from a fresh pointer.
        do_reset();
        for (int i = 0; i < NS; i++)
            for (int n = 0; n < 2; n++) srcq[i].push_back(mk_rand());
        run_pass(100, -1, -1);

        // Empty pass: all sources finished before the frame opens.
        run_pass(100, -1, -1);

        // Reset in the middle of broadcasting, then a clean pass.
        for (int i = 0; i < NS; i++)
            for (int n = 0; n < 4; n++) srcq[i].push_back(mk_rand());
        run_pass(100, -1, 4);
        for (int i = 0; i < NS; i++)
            for (int n = 0; n < 2; n++) srcq[i].push_back(mk_rand());
        run_pass(100, -1, -1);

        // start pulsed during SETTLE must be ignored.
        for (int n = 0; n < 2; n++) srcq[2].push_back(mk_rand());
        run_pass(80, 1, -1);

`ifdef MU_SCHED_CELL_CHECK_EN
        // Illegal destination between two legal ones; flag holds until start.
        srcq[1].push_back(mk(1, 1, 1));
        srcq[1].push_back(mk(5, 1, 1));
        srcq[1].push_back(mk(2, 2, 2));
        run_pass(100, -1, -1);
        run_pass(100, -1, -1);
`endif

        // Randomised passes.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NS; i++) begin
                int cnt;
                cnt = $urandom_range(0, 5);
                for (int n = 0; n < cnt; n++) srcq[i].push_back(mk_rand());
            end
            run_pass($urandom_range(30, 100),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SC - 1)) : -1,
                     -1);
        end

        @(negedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
